packet_snooper: RTL and testbench

Upstream fill stage for the packet RAM: accepts a word-wide packet stream, writes consecutive words into packet RAM port A from address 0, and hands the completed packet to the BPF CPU with its byte length. Holds off the stream while the CPU owns the buffer, then re-arms for the next packet when the CPU signals done. Packets longer than the RAM are truncated and flagged.

---
 rtl/bpf_defs_pkg.sv | 16 +
 rtl/packet_snooper_if.sv | 21 ++
 rtl/packet_snooper.sv | 130 +++++++++++++
 tb/tb_packet_snooper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpf_defs_pkg.sv
// Definitions shared by the packet snooper, packet RAM and BPF CPU:
// buffer geometry, word size and the snooper state encoding.
package bpf_defs_pkg;

  localparam int PACKET_ADDR_WIDTH = 10;
  localparam int WORD_BITS         = 32;
  localparam int WORD_BYTES        = WORD_BITS / 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITING = 2'd1,
    DRAIN   = 2'd2,
    HANDOFF = 2'd3
  } snoop_state_e;

endpackage

// File: rtl/packet_snooper_if.sv
// Word-wide packet stream into the snooper. The master drives words.
// The slave returns snoop_ready.
interface packet_snooper_if;

  logic [31:0] snoop_data;
  logic        snoop_valid;
  logic        snoop_last;
  logic [1:0]  snoop_bytes;
  logic        snoop_ready;

  modport master (
    output snoop_data, snoop_valid, snoop_last, snoop_bytes,
    input  snoop_ready
  );

  modport slave (
    input  snoop_data, snoop_valid, snoop_last, snoop_bytes,
    output snoop_ready
  );

endinterface

// File: rtl/packet_snooper.sv
// Fills packet RAM port A from the snoop stream and hands the packet to the CPU.
// Optional SNOOP_BYTE_VALID_EN: the final word reports a partial byte count.
module packet_snooper
  import bpf_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = PACKET_ADDR_WIDTH,
  parameter int DATA_WIDTH = WORD_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  packet_snooper_if.slave         snoop,
  output logic                    ram_en,
  output logic                    ram_wr_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wr_data,
  output logic                    rdy_for_cpu,
  output logic [ADDR_WIDTH+2:0]   byte_length,
  output logic                    truncated,
  input  logic                    cpu_done
);

  localparam int LW = ADDR_WIDTH + 3;

  snoop_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0]   ptr_q;      // next word address; reaches 2^ADDR_WIDTH on overflow
  logic                  trunc_q;
  logic                  beat;
  logic                  wr_beat;
  logic                  ptr_at_top;
  logic                  release_buf;
  logic [LW-1:0]         word_bytes;
  logic [LW-1:0]         len_calc;

  // Ready is decoded from the state register alone, so there is no input-to-output path.
  assign snoop.snoop_ready = (state_q != HANDOFF);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, WRITING: begin
        if (beat) begin
          if (snoop.snoop_last) state_d = HANDOFF;
          else if (ptr_at_top)  state_d = DRAIN;
          else                  state_d = WRITING;
        end
      end
      DRAIN:   if (beat && snoop.snoop_last) state_d = HANDOFF;
      HANDOFF: if (cpu_done)                 state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    beat        = snoop.snoop_valid && snoop.snoop_ready;
    wr_beat     = beat && ((state_q == IDLE) || (state_q == WRITING));
    ptr_at_top  = (ptr_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}});
    release_buf = (state_q == HANDOFF) && cpu_done;
    word_bytes  = {ptr_q, 2'b00};
  end

`ifdef SNOOP_BYTE_VALID_EN
  logic [1:0] last_bytes_q;
  logic [2:0] tail_bytes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              last_bytes_q <= 2'd0;
    else if (wr_beat && snoop.snoop_last) last_bytes_q <= snoop.snoop_bytes;
  end

  // Only the final word is partial; a truncated packet always reports the full buffer.
  always_comb begin
    tail_bytes = (last_bytes_q == 2'd0) ? 3'd4 : {1'b0, last_bytes_q};
    len_calc   = trunc_q ? word_bytes : word_bytes - LW'(4) + LW'(tail_bytes);
  end
`else
  logic unused_snoop_bytes;
  assign unused_snoop_bytes = ^snoop.snoop_bytes;

  always_comb len_calc = word_bytes;
`endif

  // Datapath: write port registers, word pointer and the CPU-facing status.
  // NOTE: only control/status flops are reset; packet RAM contents are deliberately left alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      trunc_q     <= 1'b0;
      ram_en      <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_addr    <= '0;
      ram_wr_data <= '0;
      rdy_for_cpu <= 1'b0;
      byte_length <= '0;
      truncated   <= 1'b0;
    end else begin
      ram_en    <= wr_beat;
      ram_wr_en <= wr_beat;
      if (wr_beat) begin
        ram_addr    <= ptr_q[ADDR_WIDTH-1:0];
        ram_wr_data <= snoop.snoop_data;
        ptr_q       <= ptr_q + 1'b1;
        if (!snoop.snoop_last && ptr_at_top) trunc_q <= 1'b1;
      end
      // Publish one cycle into HANDOFF, after the final RAM write has committed.
      if ((state_q == HANDOFF) && !rdy_for_cpu) begin
        rdy_for_cpu <= 1'b1;
        byte_length <= len_calc;
        truncated   <= trunc_q;
      end
      if (release_buf) begin
        ptr_q       <= '0;
        trunc_q     <= 1'b0;
        rdy_for_cpu <= 1'b0;
        byte_length <= '0;
        truncated   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packet_snooper.sv
// Scoreboard bench for packet_snooper: stimulus pushes expected RAM writes and
// packet reports, a negedge monitor pops and compares them.
module tb_packet_snooper;
  import bpf_defs_pkg::*;

  localparam int AW    = PACKET_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_en, ram_wr_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wr_data;
  logic          rdy_for_cpu;
  logic [AW+2:0] byte_length;
  logic          truncated;
  logic          cpu_done;

  always #5 clk = ~clk;

  packet_snooper_if snoop_bus ();

  packet_snooper dut (
    .clk         (clk),
    .rst         (rst),
    .snoop       (snoop_bus),
    .ram_en      (ram_en),
    .ram_wr_en   (ram_wr_en),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .rdy_for_cpu (rdy_for_cpu),
    .byte_length (byte_length),
    .truncated   (truncated),
    .cpu_done    (cpu_done)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    int   len;
    logic trunc;
  } pkt_t;

  wr_t  wr_q[$];
  pkt_t pkt_q[$];

  int n_checks     = 0;
  int n_errors     = 0;
  int cyc          = 0;
  int last_acc_cyc = -100;
  int exp_addr     = 0;

`ifdef SNOOP_BYTE_VALID_EN
  localparam int LEN_2W_1B = 5;
`else
  localparam int LEN_2W_1B = 8;
`endif

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every RAM write and every packet hand-off against the queues.
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin : monitor
    wr_t  ew;
    pkt_t ep;
    if (rst) begin
      rdy_prev = 1'b0;
    end else begin
      if (ram_en || ram_wr_en) begin
        if (wr_q.size() == 0) begin
          check("no_write_expected", ram_en, 1'b0);
        end else begin
          ew = wr_q.pop_front();
          check("wr_enables", {ram_en, ram_wr_en}, 2'b11);
          check("wr_addr", ram_addr, ew.addr);
          check("wr_data", ram_wr_data, ew.data);
        end
      end
      if (rdy_for_cpu && !rdy_prev) begin
        if (pkt_q.size() == 0) begin
          check("no_rdy_expected", rdy_for_cpu, 1'b0);
        end else begin
          ep = pkt_q.pop_front();
          check("rdy_latency", cyc, last_acc_cyc + 1);
          check("byte_length", byte_length, ep.len);
          check("truncated", truncated, ep.trunc);
        end
      end
      // Inputs are stable here; a last beat seen now is accepted on the coming edge.
      if (snoop_bus.snoop_valid && snoop_bus.snoop_ready && snoop_bus.snoop_last)
        last_acc_cyc = cyc + 1;
      rdy_prev = rdy_for_cpu;
    end
  end

  task automatic idle();
    snoop_bus.snoop_valid = 1'b0;
    snoop_bus.snoop_last  = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [1:0] b);
    int t = 0;
    snoop_bus.snoop_data  = d;
    snoop_bus.snoop_valid = 1'b1;
    snoop_bus.snoop_last  = l;
    snoop_bus.snoop_bytes = b;
    while (!snoop_bus.snoop_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 50) check("ready_timeout", snoop_bus.snoop_ready, 1'b1);
    if (exp_addr < DEPTH) wr_q.push_back('{addr: exp_addr[AW-1:0], data: d});
    exp_addr++;
    @(posedge clk); #1;
  endtask

  task automatic packet(input int n, input logic [31:0] base, input int len, input logic tr);
    pkt_q.push_back('{len: len, trunc: tr});
    for (int i = 0; i < n; i++) beat(base + i, (i == n - 1), 2'd0);
    idle();
  endtask

  task automatic wait_rdy();
    int t = 0;
    while (!rdy_for_cpu && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t == 20) check("rdy_timeout", rdy_for_cpu, 1'b1);
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1;
    @(posedge clk); #1;
    cpu_done = 1'b0;
  endtask

  task automatic release_buf();
    pulse_done();
    exp_addr = 0;
    check("ready_after_done", snoop_bus.snoop_ready, 1'b1);
    check("rdy_cleared", rdy_for_cpu, 1'b0);
    check("len_cleared", byte_length, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, snoop_bus.snoop_ready, 1'b1);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    check({tag, "_ram_wr_en"}, ram_wr_en, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wr_data"}, ram_wr_data, 0);
    check({tag, "_rdy"}, rdy_for_cpu, 1'b0);
    check({tag, "_len"}, byte_length, 0);
    check({tag, "_trunc"}, truncated, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst                   = 1'b1;
    cpu_done              = 1'b0;
    snoop_bus.snoop_data  = '0;
    snoop_bus.snoop_valid = 1'b0;
    snoop_bus.snoop_last  = 1'b0;
    snoop_bus.snoop_bytes = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Three-word packet
    pkt_q.push_back('{len: 12, trunc: 1'b0});
    beat(32'hDEADBEEF, 1'b0, 2'd0);
    beat(32'hBEEFCAFE, 1'b0, 2'd0);
    beat(32'hCAFEDEAD, 1'b1, 2'd0);
    idle();
    wait_rdy();

    // Stream held off while the CPU owns the buffer
    snoop_bus.snoop_data  = 32'h12345678;
    snoop_bus.snoop_valid = 1'b1;
    snoop_bus.snoop_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ready_in_handoff", snoop_bus.snoop_ready, 1'b0);
      @(posedge clk); #1;
    end
    check("rdy_held", rdy_for_cpu, 1'b1);
    pkt_q.push_back('{len: 4, trunc: 1'b0});
    release_buf();
    beat(32'h12345678, 1'b1, 2'd0);
    idle();
    wait_rdy();
    release_buf();

    // Partial final word; bytes on a non-last beat must be ignored
    pkt_q.push_back('{len: LEN_2W_1B, trunc: 1'b0});
    beat(32'hA0A0A0A0, 1'b0, 2'd3);
    beat(32'hA1A1A1A1, 1'b1, 2'd1);
    idle();
    wait_rdy();
    release_buf();
    pkt_q.push_back('{len: 8, trunc: 1'b0});
    beat(32'hB0B0B0B0, 1'b0, 2'd2);
    beat(32'hB1B1B1B1, 1'b1, 2'd0);
    idle();
    wait_rdy();
    release_buf();

    // Overflow: 1030 words truncate, then exactly 1024 words fit
    packet(DEPTH + 6, 32'h1000_0000, 4 * DEPTH, 1'b1);
    wait_rdy();
    release_buf();
    packet(DEPTH, 32'h2000_0000, 4 * DEPTH, 1'b0);
    wait_rdy();
    release_buf();

    // Reset in the middle of a packet
    beat(32'h3000_0000, 1'b0, 2'd0);
    beat(32'h3000_0001, 1'b0, 2'd0);
    idle();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst      = 1'b0;
    exp_addr = 0;
    packet(1, 32'h4444_4444, 4, 1'b0);
    wait_rdy();
    release_buf();

    // cpu_done outside HANDOFF has no effect
    pulse_done();
    check("idle_done_ready", snoop_bus.snoop_ready, 1'b1);
    check("idle_done_rdy", rdy_for_cpu, 1'b0);
    pkt_q.push_back('{len: 8, trunc: 1'b0});
    beat(32'h5555_0000, 1'b0, 2'd0);
    idle();
    pulse_done();
    check("writing_done_ready", snoop_bus.snoop_ready, 1'b1);
    check("writing_done_rdy", rdy_for_cpu, 1'b0);
    beat(32'h5555_0001, 1'b1, 2'd0);
    idle();
    wait_rdy();
    release_buf();

    repeat (5) @(posedge clk);
    #1;
    check("wr_queue_drained", wr_q.size(), 0);
    check("pkt_queue_drained", pkt_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
